// File: rtl/sram_pkg.sv
`default_nettype none
// ---------------------------------------------------------------------------
// sram_pkg : shared geometry and word type for the 64x128 bit-write SRAM
// Rev 1.0
// ---------------------------------------------------------------------------
package sram_pkg;
  localparam int SRAM_DATA_W = 128;
  localparam int SRAM_ADDR_W = 6;
  localparam int SRAM_DEPTH  = 64;

  typedef logic [SRAM_DATA_W-1:0] sram_word_t;
endpackage
`default_nettype wire

// File: rtl/sram_bw_merge.sv
`default_nettype none
// ---------------------------------------------------------------------------
// sram_bw_merge : active-low bit-mask merge, bwen=0 selects new_word bit
// Rev 1.0
// ---------------------------------------------------------------------------
module sram_bw_merge
  import sram_pkg::*;
#(
  parameter int DATA_W = SRAM_DATA_W
) (
  input  logic [DATA_W-1:0] old_word,
  input  logic [DATA_W-1:0] new_word,
  input  logic [DATA_W-1:0] bwen,
  output logic [DATA_W-1:0] merged
);
  assign merged = (old_word & bwen) | (new_word & ~bwen);
endmodule
`default_nettype wire

// File: rtl/sram_sp_64x128_bw.sv
`default_nettype none
// ---------------------------------------------------------------------------
// sram_sp_64x128_bw : behavioural single-port SRAM, 1-cycle read, bit write mask
// Optional macro SRAM_WRITE_THROUGH_EN: rdata returns merged word on writes.
// Rev 1.0
// ---------------------------------------------------------------------------
module sram_sp_64x128_bw
  import sram_pkg::*;
#(
  parameter int DATA_W = SRAM_DATA_W,
  parameter int ADDR_W = SRAM_ADDR_W,
  parameter int DEPTH  = SRAM_DEPTH
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              cen,
  input  logic              wen,
  input  logic [DATA_W-1:0] bwen,
  input  logic [ADDR_W-1:0] addr,
  input  logic [DATA_W-1:0] wdata,
  output logic [DATA_W-1:0] rdata
);
  localparam int IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [DATA_W-1:0] mem [DEPTH];
  logic [IDX_W-1:0]  idx;
  logic              in_range;
  logic              rd_en;
  logic              wr_en;
  logic [DATA_W-1:0] old_word;
  logic [DATA_W-1:0] merged;

  // X on cen/wen makes both enables non-true, so the array is left alone.
  assign rd_en = !cen && wen;
  assign wr_en = !cen && !wen;
  assign idx   = addr[IDX_W-1:0];

  generate
    if (DEPTH < (2 ** ADDR_W)) begin : g_partial
      assign in_range = ({1'b0, addr} < (ADDR_W + 1)'(DEPTH));
    end else begin : g_full
      assign in_range = 1'b1;
    end
  endgenerate

  assign old_word = in_range ? mem[idx] : '0;

  sram_bw_merge #(.DATA_W(DATA_W)) u_merge (
    .old_word (old_word),
    .new_word (wdata),
    .bwen     (bwen),
    .merged   (merged)
  );

  // Array is deliberately not reset; reset only blocks the access.
  always_ff @(posedge clock) begin
    if (!reset && wr_en && in_range) begin
      mem[idx] <= merged;
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      rdata <= '0;
    end else if (rd_en) begin
      rdata <= old_word;
`ifdef SRAM_WRITE_THROUGH_EN
    end else if (wr_en && in_range) begin
      rdata <= merged;
`endif
    end
  end

`ifndef SYNTHESIS
  always @(posedge clock) begin
    if (!reset && $isunknown({cen, wen})) begin
      $display("WARNING: %m unknown cen/wen at %0t, access ignored", $time);
    end
  end
`endif
endmodule
`default_nettype wire

// File: tb/tb_sram_sp_64x128_bw.sv
`default_nettype none
// Directed scoreboard bench for sram_sp_64x128_bw; expected rdata is queued
// when each access is driven and popped one edge later.
module tb_sram_sp_64x128_bw;
  localparam int DW = 128;

  typedef struct {
    string         tag;
    logic [DW-1:0] data;
  } exp_t;

  logic          clock = 1'b0;
  logic          reset;
  logic          cen;
  logic          wen;
  logic [DW-1:0] bwen;
  logic [5:0]    addr;
  logic [DW-1:0] wdata;
  logic [DW-1:0] rdata;

  logic [DW-1:0] model [64];
  logic [DW-1:0] exp_rdata;
  exp_t          exp_q[$];
  int            n_cmp = 0;
  int            n_err = 0;

  sram_sp_64x128_bw dut (
    .clock (clock),
    .reset (reset),
    .cen   (cen),
    .wen   (wen),
    .bwen  (bwen),
    .addr  (addr),
    .wdata (wdata),
    .rdata (rdata)
  );

  always #5 clock = ~clock;

  task automatic check(input string tag, input logic [DW-1:0] obs, input logic [DW-1:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic step();
    exp_t e;
    @(posedge clock);
    #1;
    if (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      check(e.tag, rdata, e.data);
    end
  endtask

  task automatic wr(input string tag, input logic [5:0] a, input logic [DW-1:0] d,
                    input logic [DW-1:0] bw);
    logic [DW-1:0] m;
    cen = 1'b0; wen = 1'b0; addr = a; wdata = d; bwen = bw;
    m = (model[a] & bw) | (d & ~bw);
    model[a] = m;
`ifdef SRAM_WRITE_THROUGH_EN
    exp_rdata = m;
`endif
    exp_q.push_back('{tag, exp_rdata});
    step();
  endtask

  task automatic rd(input string tag, input logic [5:0] a);
    cen = 1'b0; wen = 1'b1; addr = a; bwen = '1;
    wdata = {4{$urandom()}};
    exp_rdata = model[a];
    exp_q.push_back('{tag, exp_rdata});
    step();
  endtask

  task automatic idle(input string tag);
    cen = 1'b1; wen = 1'($urandom()); addr = 6'($urandom());
    wdata = {4{$urandom()}}; bwen = {4{$urandom()}};
    exp_q.push_back('{tag, exp_rdata});
    step();
  endtask

  initial begin
    logic [DW-1:0] mask;
    reset = 1'b1; cen = 1'b1; wen = 1'b1; bwen = '1; addr = '0; wdata = '0;
    exp_rdata = '0;
    repeat (2) @(posedge clock);
    #1;
    check("reset_rdata", rdata, '0);
    reset = 1'b0;

    // Full-word write then read
    wr("wr5", 6'd5, 128'h0123456789ABCDEF0123456789ABCDEF, '0);
    rd("rd5_full", 6'd5);

    // Masked write: only the low byte is cleared
    wr("wr9_ones", 6'd9, '1, '0);
    mask = {{120{1'b1}}, 8'h00};
    wr("wr9_mask", 6'd9, '0, mask);
    rd("rd9_masked", 6'd9);
    check("model9", model[9], {{120{1'b1}}, 8'h00});

    // Idle hold: rdata and mem[5] unchanged
    rd("rd5_pre_idle", 6'd5);
    for (int i = 0; i < 10; i++) idle("idle_hold");
    rd("rd5_post_idle", 6'd5);

    // No-op write with all-ones mask
    wr("wr5_noop", 6'd5, '0, '1);
    rd("rd5_after_noop", 6'd5);

    // Write-through behaviour (rdata = R beforehand)
    rd("rd9_R", 6'd9);
    wr("wr3_wt", 6'd3, {16{8'hA5}}, '0);
    rd("rd3", 6'd3);

    // Sweep: write all, read back-to-back
    for (int i = 0; i < 64; i++) wr("sweep_wr", 6'(i), {16{8'(i) ^ 8'h55}}, '0);
    for (int i = 0; i < 64; i++) rd("sweep_rd", 6'(i));

    // Reset asserted mid-access: rdata clears asynchronously, write discarded
    rd("rd5_nonzero", 6'd5);
    cen = 1'b0; wen = 1'b0; addr = 6'd5; wdata = '0; bwen = '0;
    #2;
    reset = 1'b1;
    #1;
    check("async_reset_clear", rdata, '0);
    exp_rdata = '0;
    exp_q.push_back('{"reset_held", exp_rdata});
    step();
    reset = 1'b0;
    rd("rd5_post_reset", 6'd5);
    rd("rd3_post_reset", 6'd3);
    idle("final_idle");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
`default_nettype wire
